fifo_rd_ctrl: RTL and testbench

Read-domain pointer and flag controller for the asynchronous FIFO, running entirely on the read clock. It accepts read requests and generates the RAM read address. It also produces the Gray-coded read pointer that the write domain's two-flop synchronizer samples. It compares that pointer with the synchronized write pointer to drive a registered empty flag and a sticky underflow flag.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_gray2bin.sv | 14 +
 rtl/fifo_rd_ctrl.sv | 81 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer logic.
// Gray/binary helpers operate on zero-extended values up to PTR_MAX bits.
package fifo_pkg;

  localparam int FIFO_AW = 4;
  localparam int PTR_MAX = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(
    input logic [PTR_MAX-1:0] b,
    input int                 w
  );
    logic [PTR_MAX-1:0] m;
    m = (PTR_MAX'(1) << w) - PTR_MAX'(1);
    return (b ^ (b >> 1)) & m;
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(
    input logic [PTR_MAX-1:0] g,
    input int                 w
  );
    logic [PTR_MAX-1:0] m;
    logic [PTR_MAX-1:0] b;
    m = (PTR_MAX'(1) << w) - PTR_MAX'(1);
    b = g & m;
    for (int i = 1; i < PTR_MAX; i++) begin
      b = b ^ ((g & m) >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer and empty/underflow flag controller for the async FIFO.
// Optional almost-empty flag is enabled by defining FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = FIFO_AW
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int ALMOST_EMPTY_TH = 2
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     R_INC,
  input  logic [ADDRESS_WIDTH:0]   Rq2_Wptr,
  output logic [ADDRESS_WIDTH-1:0] R_ADDR,
  output logic [ADDRESS_WIDTH:0]   R_ptr,
  output logic                     R_EMPTY,
  output logic                     R_UNDERFLOW
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                     R_ALMOST_EMPTY
`endif
);

  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic          rd_en;
  logic          empty_next;

  assign rd_en      = R_INC & ~R_EMPTY;
  assign rbin_next  = rbin + PW'(rd_en);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Compare against the post-read pointer so the last read empties at once.
  assign empty_next = (rgray_next == Rq2_Wptr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rbin        <= '0;
      R_ptr       <= '0;
      R_EMPTY     <= 1'b1;
      R_UNDERFLOW <= 1'b0;
    end else begin
      rbin    <= rbin_next;
      R_ptr   <= rgray_next;
      R_EMPTY <= empty_next;
      if (R_INC && R_EMPTY) begin
        R_UNDERFLOW <= 1'b1;
      end
    end
  end

  assign R_ADDR = rbin[ADDRESS_WIDTH-1:0];

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PW-1:0] wbin;
  logic [PW-1:0] occupancy;

  fifo_gray2bin #(
    .W (PW)
  ) u_g2b (
    .gray (Rq2_Wptr),
    .bin  (wbin)
  );

  assign occupancy = wbin - rbin_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_ALMOST_EMPTY <= 1'b1;
    end else begin
      R_ALMOST_EMPTY <= (occupancy <= PW'(ALMOST_EMPTY_TH));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with ADDRESS_WIDTH=4.
// Stimulus queues hand-computed post-edge expectations; a monitor checks them.
module tb_fifo_rd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       R_INC;
  logic [4:0] Rq2_Wptr;
  logic [3:0] R_ADDR;
  logic [4:0] R_ptr;
  logic       R_EMPTY;
  logic       R_UNDERFLOW;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       R_ALMOST_EMPTY;
`endif

  always #5 CLK = ~CLK;

  fifo_rd_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .R_INC          (R_INC),
    .Rq2_Wptr       (Rq2_Wptr),
    .R_ADDR         (R_ADDR),
    .R_ptr          (R_ptr),
    .R_EMPTY        (R_EMPTY),
    .R_UNDERFLOW    (R_UNDERFLOW)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .R_ALMOST_EMPTY (R_ALMOST_EMPTY)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       empty;
    logic       uf;
    logic       moved;
    logic       chk_ae;
    logic       ae;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input string nm, input logic inc, input logic [4:0] w,
                      input logic [3:0] a, input logic [4:0] p,
                      input logic em, input logic u, input logic mv,
                      input logic cae = 1'b0, input logic ae = 1'b0);
    exp_t e;
    @(negedge CLK);
    R_INC    = inc;
    Rq2_Wptr = w;
    e.name   = nm;
    e.addr   = a;
    e.ptr    = p;
    e.empty  = em;
    e.uf     = u;
    e.moved  = mv;
    e.chk_ae = cae;
    e.ae     = ae;
    q.push_back(e);
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, ".ptr"},   32'(R_ptr),       32'd0);
    chk({nm, ".addr"},  32'(R_ADDR),      32'd0);
    chk({nm, ".empty"}, 32'(R_EMPTY),     32'd1);
    chk({nm, ".uf"},    32'(R_UNDERFLOW), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk({nm, ".ae"},    32'(R_ALMOST_EMPTY), 32'd1);
`endif
  endtask

  function automatic logic [4:0] g(input int i);
    logic [4:0] b;
    b = 5'(i);
    return b ^ (b >> 1);
  endfunction

  // Monitor: one expectation per clock edge while the queue is non-empty.
  logic [4:0] prev_ptr = '0;
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".addr"},  32'(R_ADDR),      32'(e.addr));
        chk({e.name, ".ptr"},   32'(R_ptr),       32'(e.ptr));
        chk({e.name, ".empty"}, 32'(R_EMPTY),     32'(e.empty));
        chk({e.name, ".uf"},    32'(R_UNDERFLOW), 32'(e.uf));
        if (e.moved) begin
          chk({e.name, ".onebit"}, 32'($countones(R_ptr ^ prev_ptr)), 32'd1);
        end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        if (e.chk_ae) begin
          chk({e.name, ".ae"}, 32'(R_ALMOST_EMPTY), 32'(e.ae));
        end
`endif
      end
      prev_ptr = R_ptr;
    end
  end

  logic [4:0] stale_g [6] = '{5'b00001, 5'b00011, 5'b00010,
                              5'b00110, 5'b00111, 5'b00101};

  initial begin
    logic [4:0] p;
    RST      = 1'b1;
    R_INC    = 1'b0;
    Rq2_Wptr = 5'b00000;
    #12;
    rst_chk("reset0");
    @(negedge CLK);
    RST = 1'b0;

    step("drain.load", 0, 5'b00010, 4'd0, 5'b00000, 0, 0, 0);
    step("drain.r1",   1, 5'b00010, 4'd1, 5'b00001, 0, 0, 1);
    step("drain.r2",   1, 5'b00010, 4'd2, 5'b00011, 0, 0, 1);
    step("drain.r3",   1, 5'b00010, 4'd3, 5'b00010, 1, 0, 1);
    step("uflow",      1, 5'b00010, 4'd3, 5'b00010, 1, 1, 0);
    step("uflow.hold", 0, 5'b00010, 4'd3, 5'b00010, 1, 1, 0);
    step("mid.w6",     0, 5'b00101, 4'd3, 5'b00010, 0, 1, 0);
    step("mid.r4",     1, 5'b00101, 4'd4, 5'b00110, 0, 1, 1);

    // Reset lands mid-cycle while R_INC is still held high.
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    rst_chk("reset.mid");
    @(negedge CLK);
    RST      = 1'b0;
    R_INC    = 1'b0;
    Rq2_Wptr = 5'b00000;

    step("stale.w6", 0, 5'b00101, 4'd0, 5'b00000, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step("stale.rd", 1, 5'b00101, 4'(i), stale_g[i-1], (i == 6), 0, 1);
    end
    step("stale.uf", 1, 5'b00101, 4'd6, 5'b00101, 1, 1, 0);

    @(negedge CLK);
    RST      = 1'b1;
    R_INC    = 1'b0;
    Rq2_Wptr = 5'b00000;
    #1;
    rst_chk("reset.wrap");
    @(negedge CLK);
    RST = 1'b0;

    step("wrap.load", 0, g(4), 4'd0, 5'b00000, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      if (i == 14)      p = 5'b01000;
      else if (i == 15) p = 5'b11000;
      else if (i == 30) p = 5'b10000;
      else if (i == 31) p = 5'b00000;
      else              p = g(i + 1);
      step("wrap", 1, g((i + 5) % 32), 4'((i + 1) % 16), p, 0, 0, 1);
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    @(negedge CLK);
    RST      = 1'b1;
    R_INC    = 1'b0;
    Rq2_Wptr = 5'b00000;
    #1;
    rst_chk("reset.ae");
    @(negedge CLK);
    RST = 1'b0;
    step("ae.load", 0, 5'b00111, 4'd0, 5'b00000, 0, 0, 0, 1, 0);
    step("ae.r1",   1, 5'b00111, 4'd1, 5'b00001, 0, 0, 1, 1, 0);
    step("ae.r2",   1, 5'b00111, 4'd2, 5'b00011, 0, 0, 1, 1, 0);
    step("ae.r3",   1, 5'b00111, 4'd3, 5'b00010, 0, 0, 1, 1, 1);
`endif

    @(negedge CLK);
    R_INC = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(posedge CLK);
    end
    #3;
    chk("sb.drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
